// File: rtl/l1_mem_port_arbiter.sv
// rtl/l1_mem_port_arbiter.sv - round-robin share of one L2 bus channel among L1 cache controllers
// Optional watchdog enabled by defining L1_ARB_TIMEOUT_EN.
module l1_mem_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int MSG_BITS       = 4,
  parameter int ADDRESS_BITS   = 32,
  parameter int CACHE_WIDTH    = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_PORTS*MSG_BITS-1:0]     cache2arb_msg,
  input  logic [NUM_PORTS*ADDRESS_BITS-1:0] cache2arb_address,
  input  logic [NUM_PORTS*CACHE_WIDTH-1:0]  cache2arb_data,
  output logic [NUM_PORTS*MSG_BITS-1:0]     arb2cache_msg,
  output logic [ADDRESS_BITS-1:0]           arb2cache_address,
  output logic [CACHE_WIDTH-1:0]            arb2cache_data,
  output logic [MSG_BITS-1:0]               arb2mem_msg,
  output logic [ADDRESS_BITS-1:0]           arb2mem_address,
  output logic [CACHE_WIDTH-1:0]            arb2mem_data,
  input  logic [MSG_BITS-1:0]               mem2arb_msg,
  input  logic [ADDRESS_BITS-1:0]           mem2arb_address,
  input  logic [CACHE_WIDTH-1:0]            mem2arb_data,
  output logic [NUM_PORTS-1:0]              grant,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_q, rr_d;

  logic [NUM_PORTS-1:0] req;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;
  logic                 found;
  logic [MSG_BITS-1:0]  owner_msg;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      req[i] = |cache2arb_msg[i*MSG_BITS +: MSG_BITS];
    end
  end

  // Scan starting just after the last owner so every requester gets its turn.
  always_comb begin
    win   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = IDX_W'((int'(rr_q) + k) % NUM_PORTS);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign owner_msg = cache2arb_msg[owner_q*MSG_BITS +: MSG_BITS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      rr_q    <= IDX_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_BUSY;
          owner_d = win;
          grant_d = NUM_PORTS'(1) << win;
        end
      end
      ST_BUSY: begin
        // Owner releasing the channel ends the transaction; any mid-flight msg change is just forwarded.
        if (owner_msg == '0) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = owner_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_BUSY);

  always_comb begin
    arb2mem_msg     = '0;
    arb2mem_address = '0;
    arb2mem_data    = '0;
    arb2cache_msg   = '0;
    if (state_q == ST_BUSY) begin
      arb2mem_msg     = owner_msg;
      arb2mem_address = cache2arb_address[owner_q*ADDRESS_BITS +: ADDRESS_BITS];
      arb2mem_data    = cache2arb_data[owner_q*CACHE_WIDTH +: CACHE_WIDTH];
      arb2cache_msg[owner_q*MSG_BITS +: MSG_BITS] = mem2arb_msg;
    end
  end

  assign arb2cache_address = mem2arb_address;
  assign arb2cache_data    = mem2arb_data;

`ifdef L1_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             wd_err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (state_d == ST_BUSY) begin
          wd_cnt_q <= '0;
        end
      end else begin
        if (wd_cnt_q != CNT_W'(TIMEOUT_CYCLES)) begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
        end
        // Flag lands on the same edge the count reaches the limit.
        if (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          wd_err_q <= 1'b1;
        end
      end
    end
  end

  assign timeout_err = wd_err_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
